// File: rtl/ws2811_frame_sequencer_if.sv
// Bus bundle for the ws2811 frame sequencer: decoder input side, channel consumer handshake,
// downstream pass-through and sticky error flags.
interface ws2811_frame_sequencer_if #(
    parameter int NUM_CH = 4
);
    logic                decData;
    logic                decClk;
    logic                decActive;
    logic [NUM_CH*8-1:0] chData;
    logic                frameValid;
    logic                frameAck;
    logic                passData;
    logic                passStrobe;
    logic                passEn;
    logic                shortFrame;
    logic                overrun;
    logic                wdogErr;
    logic                errClr;

    modport master (
        input  decData, decClk, decActive, frameAck, errClr,
        output chData, frameValid, passData, passStrobe, passEn, shortFrame, overrun, wdogErr
    );

    modport slave (
        output decData, decClk, decActive, frameAck, errClr,
        input  chData, frameValid, passData, passStrobe, passEn, shortFrame, overrun, wdogErr
    );
endinterface

// File: rtl/ws2811_frame_sequencer.sv
// Captures the first NUM_CH bytes of each decoded ws2811 frame, forwards the rest downstream and
// commits the capture at end of frame. Define WS2811_SEQ_WDOG_EN to enable the stalled-frame watchdog.
module ws2811_frame_sequencer #(
    parameter int NUM_CH   = 4,
    parameter int WDOG_CYC = 2000
) (
    input logic                      masterClk,
    input logic                      nReset,
    ws2811_frame_sequencer_if.master bus
);
    localparam int TOTAL_BITS = NUM_CH * 8;
    localparam int CNT_W      = $clog2(TOTAL_BITS) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TOTAL_BITS);

    localparam logic [1:0] SYNC    = 2'd0;
    localparam logic [1:0] IDLE    = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] PASS    = 2'd3;

    if (NUM_CH < 1 || NUM_CH > 16 || WDOG_CYC < 1) begin : gBadParam
        $error("ws2811_frame_sequencer: NUM_CH must be 1..16 and WDOG_CYC at least 1");
    end

    logic [1:0]            state, stateNext;
    logic                  prevDecClk, bitValid, bitData, bitEdge;
    logic [CNT_W-1:0]      bitCnt, bitCntNext;
    logic [TOTAL_BITS-1:0] shadow, shadowNext, chDataReg;
    logic                  frameValidReg, shortReg, overrunReg;
    logic                  commit, shortSet, overrunSet, wdogHit;

    assign bitEdge = bus.decClk & ~prevDecClk & bus.decActive;

    // The registered bit lands MSB-first in the byte selected by bitCnt[..:3].
    always_comb begin
        shadowNext = shadow;
        bitCntNext = bitCnt;
        if (bitValid && state == CAPTURE) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (int'(bitCnt >> 3) == k)
                    shadowNext[8*k +: 8] = {shadow[8*k +: 7], bitData};
            end
            bitCntNext = bitCnt + 1'b1;
        end
    end

    // The pending bit is folded in before decActive low is judged, so a last bit coinciding
    // with the end of frame still completes the capture.
    always_comb begin
        stateNext = state;
        commit    = 1'b0;
        shortSet  = 1'b0;
        case (state)
            SYNC:    if (!bus.decActive) stateNext = IDLE;
            IDLE:    if (bus.decActive) stateNext = CAPTURE;
            CAPTURE: begin
                if (wdogHit) begin
                    stateNext = SYNC;
                end else if (!bus.decActive) begin
                    if (bitCntNext == CNT_FULL) commit = 1'b1;
                    else                        shortSet = 1'b1;
                    stateNext = IDLE;
                end else if (bitCntNext == CNT_FULL) begin
                    stateNext = PASS;
                end
            end
            PASS: begin
                if (wdogHit) begin
                    stateNext = SYNC;
                end else if (!bus.decActive) begin
                    commit    = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = SYNC;
        endcase
    end

    assign overrunSet = commit & frameValidReg & ~bus.frameAck;

    always_ff @(posedge masterClk or negedge nReset) begin
        if (!nReset) begin
            state         <= SYNC;
            prevDecClk    <= 1'b0;
            bitValid      <= 1'b0;
            bitData       <= 1'b0;
            bitCnt        <= '0;
            shadow        <= '0;
            chDataReg     <= '0;
            frameValidReg <= 1'b0;
            shortReg      <= 1'b0;
            overrunReg    <= 1'b0;
        end else begin
            state      <= stateNext;
            prevDecClk <= bus.decClk;
            bitValid   <= bitEdge;
            if (bitEdge) bitData <= bus.decData;

            if (state == IDLE && bus.decActive) begin
                bitCnt <= '0;
                shadow <= '0;
            end else begin
                bitCnt <= bitCntNext;
                shadow <= shadowNext;
            end

            // A commit always leaves a frame pending, even if the old one is acked this cycle.
            if (commit) begin
                chDataReg     <= shadowNext;
                frameValidReg <= 1'b1;
            end else if (bus.frameAck && frameValidReg) begin
                frameValidReg <= 1'b0;
            end

            shortReg   <= shortSet   | (shortReg   & ~bus.errClr);
            overrunReg <= overrunSet | (overrunReg & ~bus.errClr);
        end
    end

`ifdef WS2811_SEQ_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYC + 1);
    logic [WDOG_W-1:0] wdogCnt;
    logic              wdogErrReg;

    assign wdogHit = bus.decActive && (wdogCnt == WDOG_W'(WDOG_CYC));

    // Counts idle cycles between bit edges while a frame is in progress; saturates at the limit.
    always_ff @(posedge masterClk or negedge nReset) begin
        if (!nReset) begin
            wdogCnt    <= '0;
            wdogErrReg <= 1'b0;
        end else begin
            if ((state == CAPTURE || state == PASS) && !bitEdge) begin
                if (wdogCnt != WDOG_W'(WDOG_CYC)) wdogCnt <= wdogCnt + 1'b1;
            end else begin
                wdogCnt <= '0;
            end
            wdogErrReg <= ((state == CAPTURE || state == PASS) && wdogHit) | (wdogErrReg & ~bus.errClr);
        end
    end

    assign bus.wdogErr = wdogErrReg;
`else
    assign wdogHit     = 1'b0;
    assign bus.wdogErr = 1'b0;
`endif

    assign bus.chData     = chDataReg;
    assign bus.frameValid = frameValidReg;
    assign bus.shortFrame = shortReg;
    assign bus.overrun    = overrunReg;
    assign bus.passEn     = (state == PASS);
    assign bus.passStrobe = bitValid && (state == PASS);
    assign bus.passData   = (state == PASS) ? bitData : 1'b0;
endmodule

// File: doc/ws2811_frame_sequencer.md
Name: ws2811_frame_sequencer

Overview:
- Controller behind the ws2811 decoder in a daisy-chained satellite.
- Consumes the decoded bit stream (data, data clock, active) and captures the first NUM_CH bytes of each frame as this satellite's channel data.
- Forwards every later bit to the downstream encoder.
- Commits captured data at end of frame, latch-on-reset like a ws2811 device, and hands it to the consumer with a valid/ack handshake.

Parameters:
- NUM_CH, 4, bytes captured per frame (1..16); channel width fixed at 8.
- WDOG_CYC, 2000, masterClk cycles without a bit edge, while active, before the frame is aborted (used only with the optional feature).

Ports:
- masterClk  in  1  master clock; all logic on its posedge.
- nReset  in  1  asynchronous, active-low reset.
- decData  in  1  decoded bit from the decoder.
- decClk  in  1  decoder data clock; each rising edge delivers one bit.
- decActive  in  1  decoder session-active flag.
- chData  out  NUM_CH*8  committed channels; ch0 = [7:0], chN = [8N+7:8N].
- frameValid  out  1  committed frame available.
- frameAck  in  1  consumer acknowledge.
- passData  out  1  forwarded bit.
- passStrobe  out  1  one-cycle pulse per forwarded bit.
- passEn  out  1  high while in PASS state.
- shortFrame  out  1  sticky: frame ended before NUM_CH*8 bits.
- overrun  out  1  sticky: commit while previous frame not acked.
- wdogErr  out  1  sticky: watchdog abort.
- errClr  in  1  synchronous clear of all sticky flags.

Behaviour:
- Reset values: all outputs 0; chData 0; shadow register 0; bitCnt 0; FSM in SYNC.
- Bit qualification:
  - prevDecClk is registered each cycle.
  - A bit edge is decClk=1 && prevDecClk=0 && decActive=1.
  - decData is sampled in the edge cycle.
  - The bit is registered and acted on in the next cycle (latency 1).
- FSM states:
  - SYNC: wait for decActive=0, then go to IDLE. This prevents joining a frame mid-stream after reset.
  - IDLE: on decActive=1, go to CAPTURE; clear bitCnt and the shadow register.
  - CAPTURE:
    - Each bit is shifted MSB-first into shadow byte bitCnt[..:3]; bitCnt increments.
    - When bitCnt reaches NUM_CH*8, go to PASS.
    - If decActive falls first: set shortFrame, discard shadow, go to IDLE.
  - PASS:
    - Each bit drives passData and a one-cycle passStrobe (1 cycle after the edge).
    - passEn=1 throughout PASS.
    - No forwarded-bit limit.
    - On decActive falling: commit shadow to chData, set frameValid, go to IDLE.
- bitCnt width is clog2(NUM_CH*8)+1; it never wraps because it saturates at transition to PASS.
- Exact-length frame: NUM_CH*8 bits then decActive low. PASS is entered with zero forwarded bits, and the commit occurs normally.
- Handshake:
  - frameValid clears the cycle after frameAck=1 is sampled with frameValid=1.
  - frameAck while frameValid=0 is ignored.
- Commit while frameValid=1:
  - Without frameAck in the same cycle: chData is overwritten (latest wins), frameValid stays 1, overrun is set.
  - With frameAck in the same cycle: chData is overwritten, frameValid stays 1, no overrun.
- Simultaneous bit edge and decActive fall: the bit is processed first, then the end-of-frame decision is applied.
- errClr and a flag-set event in the same cycle: set wins.
- Reset mid-frame: asynchronous clear of everything; return to SYNC. No partial commit. chData stays 0 until the next full frame.

Optional Feature:
- Macro WS2811_SEQ_WDOG_EN.
- Defined:
  - A counter runs in CAPTURE/PASS and clears on each bit edge.
  - When it reaches WDOG_CYC while decActive=1: set wdogErr, discard shadow without commit, go to SYNC.
- Undefined: no counter; wdogErr is tied to 0.

Test Plan:
- NUM_CH=4; frame of 4 bytes 0x12,0x34,0x56,0x78 then decActive low -> chData=0x78563412, frameValid=1, zero passStrobe pulses; frameAck -> frameValid=0 next cycle.
- 6-byte frame, bytes 5-6 = 0xA5,0x3C -> 16 passStrobe pulses with passData 1010010100111100, passEn high from bit 33 to frame end; chData = first 4 bytes.
- Frame of 20 bits then decActive low -> shortFrame=1, frameValid stays 0, chData unchanged; errClr -> shortFrame=0.
- Two full frames, no ack between -> second data in chData, overrun=1; repeat with frameAck coinciding with commit -> overrun stays 0, frameValid=1.
- Assert nReset mid-CAPTURE while decActive stays high -> outputs 0; the remainder of that frame is ignored (SYNC); the next frame after decActive low captures correctly.
- With WS2811_SEQ_WDOG_EN, WDOG_CYC=2000: 10 bits, then decActive held high with no decClk edges for 2000 cycles -> wdogErr=1, no commit; a subsequent clean frame commits.
